ov7725_sccb_config: RTL and testbench
=====================================

# ov7725_sccb_config

Walks the OV7725 register initialisation table and writes each entry to the camera over the SCCB (I2C-like) 3-phase write protocol. It drives the table's `addr`, samples its registered 16-bit `{reg, value}` word one clock later, and serialises device ID 0x42, register address and value onto SIO_C/SIO_D. It sits between the init table and the camera pins, and signals `done` to the capture path once configuration is complete.

## Interface
- `CLK_FREQ`, 25_000_000, system clock frequency in Hz.
- `SCCB_FREQ`, 250_000, SIO_C bit rate in Hz. `DIV = CLK_FREQ/(4*SCCB_FREQ)` must be ≥ 1.
- `TABLE_SIZE`, 68, number of table entries to write, at addresses 0..TABLE_SIZE-1.
- `RESET_WAIT`, 25_000, idle clocks after writing entry 0 (soft reset 0x12_80).
- `DEV_ID`, 8'h42, SCCB write ID.
- `clk`, in, 1, system clock. All logic is on the rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `start`, in, 1, single-cycle pulse that begins configuration. Ignored while `busy`.
- `tbl_addr`, out, 8, table address.
- `tbl_data`, in, 16, table word. `[15:8]` is the register, `[7:0]` is the value. The table registers it, so it is valid 1 clk after `tbl_addr` changes.
- `sio_c`, out, 1, SCCB clock.
- `sio_d_out`, out, 1, SCCB data.
- `sio_d_oe`, out, 1, data output enable. 0 means release the line (pull-up).
- `busy`, out, 1, high from `start` until `done`.
- `done`, out, 1, sticky completion flag. Cleared by `rst` or a new `start`.
- `reg_count`, out, 8, number of entries fully written.

## Operation
- Tick generator: a counter wraps every `DIV` clks and produces a 1-clk `tick`. One bit time is 4 ticks, numbered q0..q3. The counter is held at 0 in IDLE/DONE.
- States: IDLE → FETCH → START → SHIFT → STOP → GAP → (WAIT_RST) → FETCH … → DONE.
- IDLE:
  - `sio_c`=1, `sio_d_out`=1, `sio_d_oe`=1, `tbl_addr`=0.
  - `start` moves to FETCH with `reg_count`=0, `done`=0, `busy`=1.
- FETCH: lasts 2 clks. Clock 1 drives `tbl_addr`. Clock 2 latches `tbl_data` into a 27-bit shift register:
  - bits 26..18 = `DEV_ID`, X
  - bits 17..9 = reg, X
  - bits 8..0 = value, X
  - X = 1, sent with `sio_d_oe`=0.
  - If `tbl_data`==16'h0000, go to DONE instead (end-of-table sentinel).
- START, 1 bit time:
  - q0: C=1, D=1.
  - q1: D=0.
  - q2: still D=0.
  - q3: C=0.
- SHIFT, 27 bit times, MSB first. Per bit:
  - q0: C=0, D changes.
  - q1: D stable.
  - q2: C=1.
  - q3: C=1.
  - During bits 18, 9 and 0, `sio_d_oe`=0. Acknowledge is don't-care and is not sampled.
- STOP, 1 bit time:
  - q0: C=0, D=0.
  - q1: C=1.
  - q2: D=1.
  - q3: hold.
- GAP: 1 bit time with C=1, D=1.
- After GAP:
  - `reg_count` increments.
  - If the entry just written was address 0, go to WAIT_RST for `RESET_WAIT` clks.
  - Next, if `tbl_addr`==TABLE_SIZE-1, go to DONE. Otherwise increment `tbl_addr` and go to FETCH.
- DONE:
  - `done`=1, `busy`=0, bus idle.
  - `start` restarts the sequence from address 0.

## Timing
- Reset values:
  - `sio_c`=1, `sio_d_out`=1, `sio_d_oe`=1.
  - `tbl_addr`=0, `busy`=0, `done`=0, `reg_count`=0.
  - State = IDLE.
- `rst` mid-transaction aborts in the next clk and returns the bus to idle immediately. No stop condition is generated.
- Per-entry latency: 2 clks (FETCH) + 30 bit times (START + 27 + STOP + GAP) = 2 + 120·DIV clks. Entry 0 adds `RESET_WAIT` clks.
- `start` and `rst` asserted in the same cycle: `rst` wins.
- `start` arriving while `busy`: it has no effect.
- `sio_d_out` changes only while `sio_c`=0, except at the START/STOP edges listed above.
- `reg_count` saturates at 255. With the default table it ends at 68.

## Test plan
- Reset, then idle 50 clks → `sio_c`=`sio_d_out`=1, `busy`=0, `done`=0, `tbl_addr`=0, no SIO_C edges.
- `DIV`=2, `TABLE_SIZE`=3, table {0x1280, 0x3D03, 0x1502}, `RESET_WAIT`=10, pulse `start` → bus model decodes writes 0x42/0x12/0x80, 0x42/0x3D/0x03, 0x42/0x15/0x02 in order. `done` rises exactly 3·(2+240)+10 clks after `start`. `reg_count`=3.
- Same setup → `sio_d_oe`=0 during exactly 3 bit times per transaction, and `sio_d_out` never toggles while `sio_c`=1 outside START/STOP.
- Table entry 1 = 0x0000 → only 1 write is issued, then DONE with `reg_count`=1.
- Assert `rst` during SHIFT bit 12 of entry 1 → next clk the bus is idle and `busy`=0. A following `start` rewrites from entry 0.
- Pulse `start` again mid-sequence → the sequence is unchanged. Pulse `start` in DONE → full sequence repeats and `done` drops for its duration.

Source files
------------

// File: rtl/ov7725_sccb_config_if.sv
// Pin bundle between the OV7725 configurator, its register init table and the SCCB pads.
// The master side drives the table address and SIO_C/SIO_D. The slave side returns the registered table word.
interface ov7725_sccb_config_if;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        sio_c;
    logic        sio_d_out;
    logic        sio_d_oe;

    modport master (
        output tbl_addr,
        output sio_c,
        output sio_d_out,
        output sio_d_oe,
        input  tbl_data
    );

    modport slave (
        input  tbl_addr,
        input  sio_c,
        input  sio_d_out,
        input  sio_d_oe,
        output tbl_data
    );
endinterface

// File: rtl/ov7725_sccb_config.sv
// Walks the OV7725 init table and writes each {reg, value} entry to the camera
// as an SCCB 3-phase write (ID, register, value), then flags done.
module ov7725_sccb_config #(
    parameter int       CLK_FREQ   = 25_000_000,
    parameter int       SCCB_FREQ  = 250_000,
    parameter int       TABLE_SIZE = 68,
    parameter int       RESET_WAIT = 25_000,
    parameter bit [7:0] DEV_ID     = 8'h42
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    ov7725_sccb_config_if.master bus,
    output logic busy,
    output logic done,
    output logic [7:0] reg_count
);

    localparam int DIV      = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WAIT_MAX = (RESET_WAIT > 0) ? RESET_WAIT - 1 : 0;
    localparam int WAIT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_SHIFT,
        S_STOP,
        S_GAP,
        S_WAIT_RST,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [1:0]         quarter_q, quarter_d;
    logic [4:0]         bit_idx_q, bit_idx_d;
    logic               fetch_ph_q, fetch_ph_d;
    logic [26:0]        shift_q, shift_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]         tbl_addr_q, tbl_addr_d;
    logic [7:0]         reg_count_q, reg_count_d;
    logic               done_q, done_d;

    logic tick;
    logic bit_end;
    logic advance;
    logic bit_timed;
    logic sio_c, sio_d_out, sio_d_oe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            quarter_q   <= '0;
            bit_idx_q   <= '0;
            fetch_ph_q  <= 1'b0;
            shift_q     <= '0;
            wait_cnt_q  <= '0;
            tbl_addr_q  <= '0;
            reg_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            quarter_q   <= quarter_d;
            bit_idx_q   <= bit_idx_d;
            fetch_ph_q  <= fetch_ph_d;
            shift_q     <= shift_d;
            wait_cnt_q  <= wait_cnt_d;
            tbl_addr_q  <= tbl_addr_d;
            reg_count_q <= reg_count_d;
            done_q      <= done_d;
        end
    end

    // The quarter-bit tick only runs while a bit is on the wire, so every START begins at q0 with a fresh count.
    always_comb begin
        bit_timed = (state_q == S_START) || (state_q == S_SHIFT) ||
                    (state_q == S_STOP)  || (state_q == S_GAP);
        tick      = (div_cnt_q == DIV_W'(DIV - 1));
        bit_end   = bit_timed && tick && (quarter_q == 2'd3);
        div_cnt_d = '0;
        quarter_d = '0;
        if (bit_timed) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            quarter_d = tick ? quarter_q + 2'd1 : quarter_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        fetch_ph_d  = fetch_ph_q;
        shift_d     = shift_q;
        wait_cnt_d  = wait_cnt_q;
        tbl_addr_d  = tbl_addr_q;
        reg_count_d = reg_count_q;
        done_d      = done_q;
        advance     = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    fetch_ph_d  = 1'b0;
                    tbl_addr_d  = '0;
                    reg_count_d = '0;
                    done_d      = 1'b0;
                end
            end
            S_FETCH: begin
                fetch_ph_d = ~fetch_ph_q;
                if (fetch_ph_q) begin
                    if (bus.tbl_data == 16'h0000) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        shift_d = {DEV_ID, 1'b1, bus.tbl_data[15:8], 1'b1,
                                   bus.tbl_data[7:0], 1'b1};
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_SHIFT;
                    bit_idx_d = 5'd26;
                end
            end
            S_SHIFT: begin
                if (bit_end) begin
                    if (bit_idx_q == 5'd0) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q - 5'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    if (reg_count_q != 8'hFF) begin
                        reg_count_d = reg_count_q + 8'd1;
                    end
                    if ((tbl_addr_q == 8'd0) && (RESET_WAIT > 0)) begin
                        state_d    = S_WAIT_RST;
                        wait_cnt_d = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_WAIT_RST: begin
                if (wait_cnt_q == WAIT_W'(WAIT_MAX)) begin
                    advance = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (tbl_addr_q == 8'(TABLE_SIZE - 1)) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                tbl_addr_d = tbl_addr_q + 8'd1;
                fetch_ph_d = 1'b0;
                state_d    = S_FETCH;
            end
        end
    end

    // Pin levels per quarter. The ack slots (bits 18, 9, 0) release SIO_D to the pull-up.
    always_comb begin
        sio_c     = 1'b1;
        sio_d_out = 1'b1;
        sio_d_oe  = 1'b1;
        unique case (state_q)
            S_START: begin
                sio_c     = (quarter_q != 2'd3);
                sio_d_out = (quarter_q == 2'd0);
            end
            S_SHIFT: begin
                sio_c     = quarter_q[1];
                sio_d_out = shift_q[bit_idx_q];
                sio_d_oe  = !((bit_idx_q == 5'd18) || (bit_idx_q == 5'd9) ||
                              (bit_idx_q == 5'd0));
            end
            S_STOP: begin
                sio_c     = (quarter_q != 2'd0);
                sio_d_out = quarter_q[1];
            end
            default: ;
        endcase
    end

    assign bus.tbl_addr  = tbl_addr_q;
    assign bus.sio_c     = sio_c;
    assign bus.sio_d_out = sio_d_out;
    assign bus.sio_d_oe  = sio_d_oe;
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = done_q;
    assign reg_count     = reg_count_q;

endmodule

// File: tb/tb_ov7725_sccb_config.sv
// Directed bench for ov7725_sccb_config: a registered table model, an SCCB bus decoder
// and a linear sequence of steps checked with immediate assertions.
module tb_ov7725_sccb_config;

    localparam int LIMIT    = 3000;
    localparam int FULL_LAT = 3 * (2 + 240) + 10;
    localparam logic [26:0] OE_MASK = 27'h7FBFDFE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] reg_count;

    ov7725_sccb_config_if bus_if ();

    ov7725_sccb_config #(
        .CLK_FREQ   (1_000_000),
        .SCCB_FREQ  (125_000),
        .TABLE_SIZE (3),
        .RESET_WAIT (10),
        .DEV_ID     (8'h42)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus_if),
        .busy      (busy),
        .done      (done),
        .reg_count (reg_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Registered init table: data follows the address by one clock.
    logic [15:0] tbl_mem [4];
    always_ff @(posedge clk) begin
        bus_if.tbl_data <= (bus_if.tbl_addr < 8'd4) ? tbl_mem[bus_if.tbl_addr[1:0]] : 16'h0000;
    end

    // SCCB decoder sampling the pins once per clock on the falling edge.
    logic        prev_c = 1'b1;
    logic        prev_line = 1'b1;
    logic        prev_rst = 1'b1;
    logic        line_now;
    logic        in_frame = 1'b0;
    int          bit_cnt = 0;
    int          c_edges = 0;
    int          violations = 0;
    logic [26:0] shreg;
    logic [26:0] oemask;
    logic [26:0] frames [$];
    logic [26:0] masks [$];

    always @(negedge clk) begin
        line_now = bus_if.sio_d_oe ? bus_if.sio_d_out : 1'b1;
        if (rst || prev_rst) begin
            in_frame = 1'b0;
        end else if (bus_if.sio_c && prev_c) begin
            if (prev_line && !line_now) begin
                if (in_frame) violations++;
                in_frame = 1'b1;
                bit_cnt  = 0;
                shreg    = '0;
                oemask   = '0;
            end else if (!prev_line && line_now) begin
                if (in_frame && bit_cnt == 28) begin
                    frames.push_back(shreg);
                    masks.push_back(oemask);
                end else begin
                    violations++;
                end
                in_frame = 1'b0;
            end
        end else if (bus_if.sio_c && !prev_c) begin
            c_edges++;
            if (in_frame) begin
                if (bit_cnt < 27) begin
                    shreg  = {shreg[25:0], line_now};
                    oemask = {oemask[25:0], bus_if.sio_d_oe};
                end
                bit_cnt++;
            end
        end
        prev_c    = bus_if.sio_c;
        prev_line = line_now;
        prev_rst  = rst;
    end

    function automatic logic [26:0] expFrame(input logic [7:0] r, input logic [7:0] v);
        return {8'h42, 1'b1, r, 1'b1, v, 1'b1};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-clock start pulse; returns just after the edge that samples it.
    task automatic applyStimulus();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts clocks until done, optionally re-pulsing start at clock pulse_at.
    task automatic waitDone(input int pulse_at, output int n);
        n = 0;
        while (n < LIMIT && done !== 1'b1) begin
            @(posedge clk);
            n++;
            #1 start = (n == pulse_at);
        end
        start = 1'b0;
    endtask

    task automatic checkFrames(input string tag, input int count, input logic [26:0] exp0,
                               input logic [26:0] exp1, input logic [26:0] exp2);
        logic [26:0] expv [3];
        logic [26:0] got;
        logic [26:0] gotm;
        expv[0] = exp0;
        expv[1] = exp1;
        expv[2] = exp2;
        checkOutput({tag, "_frames"}, frames.size(), count);
        for (int i = 0; i < count; i++) begin
            got  = (i < frames.size()) ? frames[i] : 27'h0;
            gotm = (i < masks.size())  ? masks[i]  : 27'h0;
            checkOutput($sformatf("%s_frame%0d", tag, i), {5'd0, got}, {5'd0, expv[i]});
            checkOutput($sformatf("%s_oe%0d", tag, i), {5'd0, gotm}, {5'd0, OE_MASK});
        end
    endtask

    int n;
    int edges0;

    initial begin
        tbl_mem[0] = 16'h1280;
        tbl_mem[1] = 16'h3D03;
        tbl_mem[2] = 16'h1502;
        tbl_mem[3] = 16'h0000;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_sio_c", bus_if.sio_c, 1);
        checkOutput("rst_sio_d", bus_if.sio_d_out, 1);
        checkOutput("rst_sio_oe", bus_if.sio_d_oe, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_tbl_addr", bus_if.tbl_addr, 0);
        checkOutput("rst_reg_count", reg_count, 0);

        edges0 = c_edges;
        repeat (50) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_c_edges", c_edges - edges0, 0);
        checkOutput("idle_sio_c", bus_if.sio_c, 1);
        checkOutput("idle_busy", busy, 0);

        $display("[TB] full table write with a stray start while busy");
        frames.delete();
        masks.delete();
        applyStimulus();
        checkOutput("run1_busy", busy, 1);
        waitDone(300, n);
        checkOutput("run1_latency", n, FULL_LAT);
        checkFrames("run1", 3, expFrame(8'h12, 8'h80), expFrame(8'h3D, 8'h03),
                    expFrame(8'h15, 8'h02));
        checkOutput("run1_violations", violations, 0);
        checkOutput("run1_reg_count", reg_count, 3);
        checkOutput("run1_busy_end", busy, 0);
        checkOutput("run1_done", done, 1);

        $display("[TB] restart from DONE");
        frames.delete();
        masks.delete();
        applyStimulus();
        checkOutput("run2_done_drop", done, 0);
        checkOutput("run2_busy", busy, 1);
        checkOutput("run2_reg_count_clr", reg_count, 0);
        waitDone(-1, n);
        checkOutput("run2_latency", n, FULL_LAT);
        checkFrames("run2", 3, expFrame(8'h12, 8'h80), expFrame(8'h3D, 8'h03),
                    expFrame(8'h15, 8'h02));
        checkOutput("run2_reg_count", reg_count, 3);

        $display("[TB] end-of-table sentinel at entry 1");
        tbl_mem[1] = 16'h0000;
        frames.delete();
        masks.delete();
        applyStimulus();
        waitDone(-1, n);
        checkOutput("sent_latency", n, 2 + 240 + 10 + 2);
        checkFrames("sent", 1, expFrame(8'h12, 8'h80), 27'h0, 27'h0);
        checkOutput("sent_reg_count", reg_count, 1);
        tbl_mem[1] = 16'h3D03;

        $display("[TB] reset during SHIFT bit 12 of entry 1");
        frames.delete();
        masks.delete();
        applyStimulus();
        repeat (377) @(posedge clk);
        #1;
        checkOutput("abort_pre_busy", busy, 1);
        checkOutput("abort_pre_sio_c", bus_if.sio_c, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_sio_c", bus_if.sio_c, 1);
        checkOutput("abort_sio_d", bus_if.sio_d_out, 1);
        checkOutput("abort_sio_oe", bus_if.sio_d_oe, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_tbl_addr", bus_if.tbl_addr, 0);
        checkOutput("abort_frames", frames.size(), 1);

        frames.delete();
        masks.delete();
        violations = 0;
        applyStimulus();
        waitDone(-1, n);
        checkOutput("rerun_latency", n, FULL_LAT);
        checkFrames("rerun", 3, expFrame(8'h12, 8'h80), expFrame(8'h3D, 8'h03),
                    expFrame(8'h15, 8'h02));
        checkOutput("rerun_violations", violations, 0);

        $display("[TB] rst and start in the same cycle");
        @(posedge clk);
        #1 begin
            rst   = 1'b1;
            start = 1'b1;
        end
        @(posedge clk);
        #1 begin
            rst   = 1'b0;
            start = 1'b0;
        end
        @(negedge clk);
        checkOutput("rst_wins_busy", busy, 0);
        checkOutput("rst_wins_done", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
